// File: rtl/regalu_sequencer.sv
// Instruction sequencer for reg_file_alu: decodes 16-bit instructions and steps the
// register-file/ALU controls through a setup/commit sequence, returning READ results.
module regalu_sequencer #(
  parameter logic [3:0] LOADI_BASE = 4'd0,
  parameter logic [1:0] LOADI_FN   = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              result_valid,
  input  logic              result_ready,
  output logic signed [7:0] result_data,
  output logic              error,
  output logic [7:0]        retired_count,
  output logic [3:0]        RA1,
  output logic [3:0]        RA2,
  output logic [3:0]        WA,
  output logic signed [7:0] external_data_in,
  output logic [1:0]        ALUcontrol,
  output logic              regwrite,
  output logic              ALUsrc,
  input  logic signed [7:0] ALUresult
);

  typedef enum logic [1:0] {IDLE, SETUP, COMMIT, RESP} state_t;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOADI = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t     state, next_state;
  logic [1:0] op_q;
  logic       is_write;

  assign is_write = (op_q != OP_READ);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // regwrite and instr_ready are gated by rst so a reset cycle never writes or accepts
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    regwrite    = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = !rst;
        if (instr_valid && instr[15:14] != OP_RSVD) next_state = SETUP;
      end
      SETUP:  next_state = COMMIT;
      COMMIT: begin
        regwrite   = is_write && !rst;
        next_state = is_write ? IDLE : RESP;
      end
      RESP:    if (result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q             <= OP_ALU;
      RA1              <= '0;
      RA2              <= '0;
      WA               <= '0;
      external_data_in <= '0;
      ALUcontrol       <= '0;
      ALUsrc           <= 1'b0;
      result_data      <= '0;
      result_valid     <= 1'b0;
      error            <= 1'b0;
      retired_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q <= instr[15:14];
            case (instr[15:14])
              OP_ALU, OP_READ: begin
                if (instr[15:14] == OP_ALU) WA <= instr[13:10];
                RA1        <= instr[9:6];
                RA2        <= instr[5:2];
                ALUcontrol <= instr[1:0];
                ALUsrc     <= 1'b0;
              end
              OP_LOADI: begin
                WA               <= instr[13:10];
                RA1              <= LOADI_BASE;
                RA2              <= LOADI_BASE;
                ALUcontrol       <= LOADI_FN;
                external_data_in <= instr[7:0];
                ALUsrc           <= 1'b1;
              end
              default: error <= 1'b1;
            endcase
          end
        end
        COMMIT: begin
          if (is_write) begin
            retired_count <= retired_count + 8'd1;
            ALUsrc        <= 1'b0;
          end else begin
            result_data  <= ALUresult;
            result_valid <= 1'b1;
          end
        end
        RESP: begin
          if (result_ready) begin
            result_valid  <= 1'b0;
            retired_count <= retired_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regalu_sequencer.sv
// Scoreboard bench for regalu_sequencer with a behavioural register file/ALU stub
// and a reference model that tracks architectural register contents per instruction.
module tb_regalu_sequencer;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              result_valid;
  logic              result_ready;
  logic signed [7:0] result_data;
  logic              error;
  logic [7:0]        retired_count;
  logic [3:0]        RA1, RA2, WA;
  logic signed [7:0] external_data_in;
  logic [1:0]        ALUcontrol;
  logic              regwrite;
  logic              ALUsrc;
  logic signed [7:0] ALUresult;

  int checks = 0;
  int errors = 0;

  regalu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .error(error), .retired_count(retired_count),
    .RA1(RA1), .RA2(RA2), .WA(WA), .external_data_in(external_data_in),
    .ALUcontrol(ALUcontrol), .regwrite(regwrite), .ALUsrc(ALUsrc), .ALUresult(ALUresult)
  );

  always #5 clk = ~clk;

  // ALU behaviour of the attached datapath: 00 add, 01 or, 10 and, 11 subtract
  function automatic logic signed [7:0] alu(input logic signed [7:0] a, input logic signed [7:0] b,
                                            input logic [1:0] fn);
    case (fn)
      2'b00:   return a + b;
      2'b01:   return a | b;
      2'b10:   return a & b;
      default: return a - b;
    endcase
  endfunction

  logic signed [7:0] regs_hw [16] = '{default: 8'sd0};
  logic              force_en = 1'b0;
  logic signed [7:0] force_val = 8'sd0;

  always_comb ALUresult = force_en ? force_val
                        : alu(regs_hw[RA1], ALUsrc ? external_data_in : regs_hw[RA2], ALUcontrol);

  always @(posedge clk) if (regwrite) regs_hw[WA] <= ALUresult;

  // Reference model state
  logic signed [7:0] regs_ref [16] = '{default: 8'sd0};
  logic [11:0]       wr_q[$];
  logic signed [7:0] rd_q[$];
  int                exp_count = 0;
  logic              exp_error = 1'b0;
  logic              rand_ready = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model(input logic [15:0] w);
    logic signed [7:0] v;
    case (w[15:14])
      2'b00: begin
        v = alu(regs_ref[w[9:6]], regs_ref[w[5:2]], w[1:0]);
        wr_q.push_back({w[13:10], v});
        regs_ref[w[13:10]] = v;
        exp_count++;
      end
      2'b01: begin
        v = regs_ref[0] | w[7:0];
        wr_q.push_back({w[13:10], v});
        regs_ref[w[13:10]] = v;
        exp_count++;
      end
      2'b10: begin
        rd_q.push_back(force_en ? force_val : alu(regs_ref[w[9:6]], regs_ref[w[5:2]], w[1:0]));
        exp_count++;
      end
      default: exp_error = 1'b1;
    endcase
  endtask

  // Offers w until accepted, updates the model, returns at the negedge after acceptance
  task automatic applyStimulus(input logic [15:0] w);
    int n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("accept timeout", n, 0);
    @(posedge clk);
    model(w);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(instr_ready && !result_valid && wr_q.size() == 0 && rd_q.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) checkOutput("idle timeout", n, 0);
  endtask

  function automatic logic [15:0] randInstr(input bit write_only);
    logic [15:0] w;
    int r;
    w = 16'($urandom);
    r = write_only ? 0 : $urandom_range(0, 9);
    if (r < 4)      w[15:14] = 2'b00;
    else if (r < 6) w[15:14] = 2'b01;
    else if (r < 9) w[15:14] = 2'b10;
    else            w[15:14] = 2'b11;
    // R0 is the LOADI base and must stay zero
    if (w[15] == 1'b0 && w[13:10] == 4'd0) w[13:10] = 4'd1;
    return w;
  endfunction

  // Scoreboard monitor: writes and result handshakes are checked against queued expectations
  always @(negedge clk) begin
    logic [11:0]       we;
    logic signed [7:0] re;
    if (regwrite) begin
      if (wr_q.size() == 0) checkOutput("unexpected write", 1, 0);
      else begin
        we = wr_q.pop_front();
        checkOutput("write addr", int'(WA), int'(we[11:8]));
        checkOutput("write data", int'(ALUresult), int'($signed(we[7:0])));
      end
    end
    if (result_valid && result_ready) begin
      if (rd_q.size() == 0) checkOutput("unexpected result", 1, 0);
      else begin
        re = rd_q.pop_front();
        checkOutput("result data", int'(result_data), int'(re));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) result_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt_before;
    rst = 1'b1;
    instr_valid = 1'b1;
    instr = 16'h0C4A;
    result_ready = 1'b0;

    // Reset held two cycles with instr_valid asserted
    repeat (2) @(negedge clk);
    checkOutput("reset instr_ready", int'(instr_ready), 0);
    checkOutput("reset regwrite", int'(regwrite), 0);
    checkOutput("reset outputs", int'(|{RA1, RA2, WA, external_data_in, ALUcontrol, ALUsrc,
                                        result_data, result_valid, error, retired_count}), 0);
    rst = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", int'(instr_ready), 1);

    // ALU op 0x0C4A
    applyStimulus(16'h0C4A);
    checkOutput("alu setup WA", int'(WA), 3);
    checkOutput("alu setup RA1", int'(RA1), 1);
    checkOutput("alu setup RA2", int'(RA2), 2);
    checkOutput("alu setup fn", int'(ALUcontrol), 2);
    checkOutput("alu setup ALUsrc", int'(ALUsrc), 0);
    checkOutput("alu setup regwrite", int'(regwrite), 0);
    @(negedge clk);
    checkOutput("alu commit regwrite", int'(regwrite), 1);
    @(negedge clk);
    checkOutput("alu retired", int'(retired_count), 1);
    checkOutput("alu ready again", int'(instr_ready), 1);

    // LOADI 0x547F
    applyStimulus(16'h547F);
    checkOutput("loadi WA", int'(WA), 5);
    checkOutput("loadi RA1", int'(RA1), 0);
    checkOutput("loadi RA2", int'(RA2), 0);
    checkOutput("loadi ALUsrc", int'(ALUsrc), 1);
    checkOutput("loadi imm", int'(external_data_in), 127);
    checkOutput("loadi fn", int'(ALUcontrol), 1);
    checkOutput("loadi setup regwrite", int'(regwrite), 0);
    @(negedge clk);
    checkOutput("loadi commit regwrite", int'(regwrite), 1);
    @(negedge clk);
    checkOutput("loadi post regwrite", int'(regwrite), 0);
    checkOutput("loadi post ALUsrc", int'(ALUsrc), 0);

    // READ with backpressure and ALUresult forced to -5
    cnt_before = int'(retired_count);
    force_val = -8'sd5;
    force_en = 1'b1;
    applyStimulus(16'h8119);
    checkOutput("read RA1", int'(RA1), 4);
    checkOutput("read RA2", int'(RA2), 6);
    checkOutput("read fn", int'(ALUcontrol), 1);
    checkOutput("read setup regwrite", int'(regwrite), 0);
    @(negedge clk);
    checkOutput("read commit regwrite", int'(regwrite), 0);
    checkOutput("read commit valid", int'(result_valid), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("read hold valid", int'(result_valid), 1);
      checkOutput("read hold data", int'(result_data), -5);
      checkOutput("read hold regwrite", int'(regwrite), 0);
      checkOutput("read hold count", int'(retired_count), cnt_before);
    end
    @(posedge clk);
    #2 result_ready = 1'b1;
    @(posedge clk);
    #2 result_ready = 1'b0;
    force_en = 1'b0;
    @(negedge clk);
    checkOutput("read done valid", int'(result_valid), 0);
    checkOutput("read done count", int'(retired_count), (cnt_before + 1) % 256);

    // Reserved opcode followed back-to-back by an ALU op
    applyStimulus(16'hC000);
    checkOutput("reserved error", int'(error), 1);
    checkOutput("reserved ready", int'(instr_ready), 1);
    applyStimulus(16'h0C4A);
    waitIdle();
    checkOutput("reserved stream count", int'(retired_count), exp_count % 256);

    // Randomized stream with random result backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) applyStimulus(randInstr(1'b0));
    waitIdle();
    checkOutput("random count", int'(retired_count), exp_count % 256);
    checkOutput("random error", int'(error), int'(exp_error));
    rand_ready = 1'b0;
    result_ready = 1'b0;

    // Reset during COMMIT drops the write and clears count and error
    instr = 16'h0C4A;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset in commit regwrite", int'(regwrite), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_count = 0;
    exp_error = 1'b0;
    @(negedge clk);
    checkOutput("reset in commit count", int'(retired_count), 0);
    checkOutput("reset in commit error", int'(error), 0);
    checkOutput("reset in commit ready", int'(instr_ready), 1);

    // 256 writes wrap retired_count back to zero
    for (int i = 0; i < 256; i++) applyStimulus(randInstr(1'b1));
    waitIdle();
    checkOutput("wrap count", int'(retired_count), 0);
    checkOutput("queues drained", wr_q.size() + rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
